// File: rtl/uart_byte_receiver.sv
// -----------------------------------------------------------------------------
// uart_byte_receiver
//
// Purpose:
//   8N1 UART receiver (LSB first) for the board IO header. The asynchronous rx
//   pin is synchronised, oversampled OVERSAMPLE times per bit, and each byte is
//   delivered to a bus-side consumer over a valid/ready handshake.
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   BAUD        line bit rate
//   OVERSAMPLE  sample ticks per bit (even, >= 8)
//   Tick divider DIV = CLK_HZ / (BAUD * OVERSAMPLE), truncated, >= 1
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   rx         in   serial line, asynchronous to clk, idles high
//   rx_data    out  received byte, stable while rx_valid is high
//   rx_valid   out  byte available
//   rx_ready   in   consumer takes the byte on a clk edge with rx_valid&&rx_ready
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   overrun    out  one-cycle pulse when a byte completes while one is still held
//   busy       out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_byte_receiver #(
    parameter int CLK_HZ     = 10_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SMP_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
    localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_prev;

    logic [DIV_W-1:0] r_div_cnt;
    logic [SMP_W-1:0] r_smp_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;

    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_tick;
    logic             w_mid;
    logic             w_restart;
    logic             w_shift;
    logic             w_complete;
    logic             w_stop_bad;
    logic             w_accept;

    // Two-flop synchroniser; r_rx_prev only keeps history for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_tick   = (r_div_cnt == DIV_LAST);
    assign w_mid    = w_tick && (r_smp_cnt == SMP_MID);
    assign w_accept = r_rx_valid && rx_ready;

    // Both counters restart on the falling edge of the start bit so the first
    // mid-bit sample lands half a bit later. The sample counter then keeps
    // wrapping every OVERSAMPLE ticks, which puts every later sample one full
    // bit further on, at the centre of each data and stop bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_smp_cnt <= '0;
        end else if (w_restart) begin
            r_div_cnt <= '0;
            r_smp_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            if (r_smp_cnt == SMP_LAST) begin
                r_smp_cnt <= '0;
            end else begin
                r_smp_cnt <= r_smp_cnt + SMP_W'(1);
            end
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_restart    = 1'b0;
        w_shift      = 1'b0;
        w_complete   = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s && r_rx_prev) begin
                    w_next_state = S_START;
                    w_restart    = 1'b1;
                end
            end
            S_START: begin
                // A start bit that is high again at its centre was a glitch.
                if (w_mid) begin
                    w_next_state = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_mid) begin
                    w_shift = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_next_state = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_mid) begin
                    if (r_rx_s) begin
                        w_complete   = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_next_state = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Stay here until the line idles so a held-low line never
                // produces a run of 0x00 frames.
                if (r_rx_s) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else if (w_restart) begin
            r_bit_idx <= 3'd0;
        end else if (w_shift) begin
            r_shift[r_bit_idx] <= r_rx_s;
            r_bit_idx          <= r_bit_idx + 3'd1;
        end
    end

    // A completion on the same edge as an acceptance replaces the outgoing
    // byte directly, so rx_valid never drops and no overrun is flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_complete && r_rx_valid && !w_accept;
            if (w_complete && (!r_rx_valid || w_accept)) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (w_accept) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_receiver
//
// Purpose:
//   Self-checking bench for uart_byte_receiver at CLK_HZ=6.4 MHz, BAUD=100k,
//   OVERSAMPLE=16 (64 clk per bit). A line driver serialises 8N1 frames; a
//   transaction-level model tracks which byte the receiver should hold, which
//   bytes the consumer should collect, and how many error pulses should occur.
// -----------------------------------------------------------------------------
module tb_uart_byte_receiver;

    localparam int CLK_HZ     = 6_400_000;
    localparam int BAUD       = 100_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = CLK_HZ / BAUD;
    // Start-edge to rx_valid: 9.5 bit times plus 3 clk of sync/edge detect.
    localparam int LATENCY    = 9 * BIT_CLKS + BIT_CLKS / 2 + 3;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b1;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_byte_receiver #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int cyc     = 0;
    int t_start = 0;
    int t_valid = 0;

    // Observed activity, collected on the falling edge.
    logic [7:0] got_q[$];
    int ferr_cnt  = 0;
    int ovr_cnt   = 0;
    int both_cnt  = 0;
    int ferr_long = 0;
    int ovr_long  = 0;
    int unstable  = 0;
    logic       prev_valid = 1'b0;
    logic       prev_acc   = 1'b0;
    logic       prev_ferr  = 1'b0;
    logic       prev_ovr   = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    // Reference model of the consumer-visible behaviour.
    logic [7:0] exp_q[$];
    logic       m_held      = 1'b0;
    logic [7:0] m_held_data = 8'h00;
    int exp_ferr = 0;
    int exp_ovr  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (frame_err && overrun) both_cnt <= both_cnt + 1;
            if (frame_err && prev_ferr) ferr_long <= ferr_long + 1;
            if (overrun && prev_ovr) ovr_long <= ovr_long + 1;
            if (rx_valid && !prev_valid) t_valid <= cyc;
            if (prev_valid && rx_valid && !prev_acc && (rx_data != prev_data))
                unstable <= unstable + 1;
        end
        prev_valid <= rx_valid;
        prev_acc   <= rx_valid && rx_ready;
        prev_ferr  <= frame_err;
        prev_ovr   <= overrun;
        prev_data  <= rx_data;
    end

    // Drives one 8N1 frame, each bit lasting bit_clks clocks. When abort_bit
    // is >= 0 the reset is pulsed halfway through that data bit and the frame
    // is abandoned.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int bit_clks, input int gap, input int abort_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        @(posedge clk);
        #1;
        t_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                repeat (bit_clks / 2) @(posedge clk);
                @(negedge clk);
                #1 reset_n = 1'b0;
                #1;
                chk("rst_data", rx_data, 8'h00);
                chk("rst_valid", rx_valid, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_ferr", frame_err, 1'b0);
                chk("rst_ovr", overrun, 1'b0);
                m_held = 1'b0;
                rx = 1'b1;
                repeat (4) @(posedge clk);
                #1 reset_n = 1'b1;
                repeat (4) @(posedge clk);
                return;
            end
            repeat (bit_clks) @(posedge clk);
            #1;
        end
        if (!stop_bit) begin
            exp_ferr++;
        end else if (rx_ready) begin
            exp_q.push_back(b);
        end else if (m_held) begin
            exp_ovr++;
        end else begin
            m_held      = 1'b1;
            m_held_data = b;
        end
        repeat (gap) @(posedge clk);
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_valid"}, rx_valid, m_held);
        if (m_held) chk({tag, "_data"}, rx_data, m_held_data);
    endtask

    task automatic release_byte();
        @(posedge clk);
        #1 rx_ready = 1'b1;
        if (m_held) begin
            exp_q.push_back(m_held_data);
            m_held = 1'b0;
        end
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        chk("valid_clr", rx_valid, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        int sk;

        // Reset state
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_data", rx_data, 8'h00);
        chk("reset_valid", rx_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ferr", frame_err, 1'b0);
        chk("reset_ovr", overrun, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);

        // Single byte held until accepted, with exact latency
        send_frame(8'hA5, 1'b1, BIT_CLKS, 20, -1);
        check_held("t1");
        chk("t1_latency", t_valid - t_start, LATENCY);
        repeat (100) @(posedge clk);
        #1 check_held("t1_hold");
        release_byte();

        // Overrun keeps the first byte
        send_frame(8'h3C, 1'b1, BIT_CLKS, 10, -1);
        send_frame(8'h81, 1'b1, BIT_CLKS, 10, -1);
        check_held("t2");
        chk("t2_ovr", ovr_cnt, exp_ovr);
        release_byte();

        // Bad stop bit and held-low line
        send_frame(8'h55, 1'b0, BIT_CLKS, 0, -1);
        repeat (100) @(posedge clk);
        #1;
        chk("t3_busy_low", busy, 1'b1);
        chk("t3_valid", rx_valid, 1'b0);
        chk("t3_ferr", ferr_cnt, exp_ferr);
        repeat (100) @(posedge clk);
        #1 rx = 1'b1;
        repeat (8) @(posedge clk);
        #1 chk("t3_busy_idle", busy, 1'b0);
        send_frame(8'h0F, 1'b1, BIT_CLKS, 10, -1);
        check_held("t3_next");
        chk("t3_latency", t_valid - t_start, LATENCY);
        release_byte();

        // Short glitch on the idle line
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("t4_busy_start", busy, 1'b1);
        repeat (10) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("t4_busy_idle", busy, 1'b0);
        check_held("t4");
        chk("t4_ferr", ferr_cnt, exp_ferr);

        // Reset in the middle of a frame, with a byte already held
        rb = 8'($urandom_range(1, 255));
        send_frame(rb, 1'b1, BIT_CLKS, 10, -1);
        check_held("t5_pre");
        send_frame(8'hF0, 1'b1, BIT_CLKS, 0, 4);
        #1 check_held("t5_post");
        send_frame(8'h12, 1'b1, BIT_CLKS, 10, -1);
        check_held("t5_next");
        release_byte();

        // Back-to-back stream with skewed line rate, consumer always ready
        @(posedge clk);
        #1 rx_ready = 1'b1;
        send_frame(8'h00, 1'b1, BIT_CLKS + 2, 0, -1);
        send_frame(8'hFF, 1'b1, BIT_CLKS - 2, 0, -1);
        send_frame(8'h6B, 1'b1, BIT_CLKS + 2, 0, -1);
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom_range(0, 255));
            sk = $urandom_range(0, 4);
            send_frame(rb, 1'b1, BIT_CLKS - 2 + sk, $urandom_range(0, 30), -1);
        end
        repeat (20) @(posedge clk);
        #1 rx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Overall bookkeeping against the model
        chk("n_bytes", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("byte%0d", i), got_q[i], exp_q[i]);
        chk("ferr_total", ferr_cnt, exp_ferr);
        chk("ovr_total", ovr_cnt, exp_ovr);
        chk("ferr_and_ovr", both_cnt, 0);
        chk("ferr_width", ferr_long, 0);
        chk("ovr_width", ovr_long, 0);
        chk("data_stable", unstable, 0);
        chk("end_valid", rx_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
